// File: rtl/chess_timer_pkg.sv
// Shared BCD time types, digit limits and helpers for the chess timer bank.
package chess_timer_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tm;
        bcd_t um;
        bcd_t ts;
        bcd_t us;
    } bcd_time_t;

    localparam bcd_t TM_MAX = 4'd9;
    localparam bcd_t UM_MAX = 4'd9;
    localparam bcd_t TS_MAX = 4'd5;
    localparam bcd_t US_MAX = 4'd9;

    localparam bcd_time_t SAT_TIME = {TM_MAX, UM_MAX, TS_MAX, US_MAX};

    function automatic bcd_time_t to_bcd_time(input int unsigned min, input int unsigned sec);
        bcd_time_t t;
        t.tm = bcd_t'(min / 10);
        t.um = bcd_t'(min % 10);
        t.ts = bcd_t'(sec / 10);
        t.us = bcd_t'(sec % 10);
        return t;
    endfunction

    function automatic logic is_zero(input bcd_time_t t);
        return t == '0;
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// One player's mm:ss BCD countdown: load, tick-decrement, digit adjust and,
// with CHESS_TIMER_INCREMENT_EN defined, a saturating Fischer increment.
module bcd_time_counter
    import chess_timer_pkg::*;
#(
    parameter int unsigned INIT_MIN = 5,
    parameter int unsigned INIT_SEC = 0
`ifdef CHESS_TIMER_INCREMENT_EN
    ,
    parameter int unsigned INC_SEC  = 0
`endif
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       inc,
    input  logic [3:0] adj_dec,
    output bcd_time_t  value,
    output logic       next_zero
);

    localparam bcd_time_t INIT_TIME = to_bcd_time(INIT_MIN, INIT_SEC);

    bcd_time_t time_q, time_d, inc_time;

`ifdef CHESS_TIMER_INCREMENT_EN
    logic [7:0] min_bin, sec_sum, min_adj, sec_adj;

    // Work in binary minutes/seconds; the carry and the 99:59 clamp are simpler there.
    always_comb begin
        min_bin = 8'(time_q.tm) * 8'd10 + 8'(time_q.um);
        sec_sum = 8'(time_q.ts) * 8'd10 + 8'(time_q.us) + 8'(INC_SEC);
        min_adj = min_bin;
        sec_adj = sec_sum;
        if (sec_sum >= 8'd60) begin
            sec_adj = sec_sum - 8'd60;
            min_adj = min_bin + 8'd1;
        end
        if (min_adj > 8'd99) begin
            inc_time = SAT_TIME;
        end else begin
            inc_time = to_bcd_time(32'(min_adj), 32'(sec_adj));
        end
    end
`else
    assign inc_time = time_q;
`endif

    always_comb begin
        time_d = time_q;
        if (tick) begin
            if (!is_zero(time_q)) begin
                if (time_q.us != 4'd0) begin
                    time_d.us = time_q.us - 4'd1;
                end else begin
                    time_d.us = US_MAX;
                    if (time_q.ts != 4'd0) begin
                        time_d.ts = time_q.ts - 4'd1;
                    end else begin
                        time_d.ts = TS_MAX;
                        if (time_q.um != 4'd0) begin
                            time_d.um = time_q.um - 4'd1;
                        end else begin
                            time_d.um = UM_MAX;
                            time_d.tm = time_q.tm - 4'd1;
                        end
                    end
                end
            end
        end else if (inc) begin
            time_d = inc_time;
        end else begin
            // Adjust wraps inside each digit and never borrows.
            if (adj_dec[0]) time_d.us = (time_q.us == 4'd0) ? US_MAX : time_q.us - 4'd1;
            if (adj_dec[1]) time_d.ts = (time_q.ts == 4'd0) ? TS_MAX : time_q.ts - 4'd1;
            if (adj_dec[2]) time_d.um = (time_q.um == 4'd0) ? UM_MAX : time_q.um - 4'd1;
            if (adj_dec[3]) time_d.tm = (time_q.tm == 4'd0) ? TM_MAX : time_q.tm - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            time_q <= INIT_TIME;
        end else begin
            time_q <= time_d;
        end
    end

    assign value     = time_q;
    assign next_zero = is_zero(time_d);

endmodule

// File: rtl/chess_timer_bank.sv
// N-player chess clock: edge detection, turn control, flagging and display mux
// around one bcd_time_counter per player. Macro CHESS_TIMER_INCREMENT_EN enables increment.
module chess_timer_bank
    import chess_timer_pkg::*;
#(
    parameter int unsigned PLAYERS  = 2,
    parameter int unsigned INIT_MIN = 5,
    parameter int unsigned INIT_SEC = 0,
    parameter int unsigned INC_SEC  = 0,
    localparam int unsigned AW = ($clog2(PLAYERS) > 1) ? $clog2(PLAYERS) : 1
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               CE,
    input  logic               IMPULSE,
    input  logic               SWITCH,
    input  logic [3:0]         ADJ_DEC,
    input  logic [AW-1:0]      ADJ_SEL,
    input  logic [AW-1:0]      DISP_SEL,
    output logic [3:0]         sec_units,
    output logic [3:0]         sec_tens,
    output logic [3:0]         min_units,
    output logic [3:0]         min_tens,
    output logic [AW-1:0]      ACTIVE,
    output logic [PLAYERS-1:0] FLAG,
    output logic               OVERFLOW
);

    if (PLAYERS < 2 || PLAYERS > 8 || INIT_MIN > 99 || INIT_SEC > 59 || INC_SEC > 59)
    begin : gen_param_check
        $error("chess_timer_bank: parameter out of range");
    end

    logic               impulse_q, switch_q;
    logic [3:0]         adj_q;
    logic               pending_q, pending_d;
    logic [AW-1:0]      active_q, active_d;
    logic [PLAYERS-1:0] flag_q, flag_d;
    logic [PLAYERS-1:0] next_zero;
    bcd_time_t          times [PLAYERS];
    bcd_time_t          disp_time;

    logic       impulse_edge, switch_edge, run, tick, sw, do_switch;
    logic [3:0] adj_edge, adj_fire;

    assign impulse_edge = IMPULSE & ~impulse_q;
    assign switch_edge  = SWITCH & ~switch_q;
    assign adj_edge     = ADJ_DEC & ~adj_q;
    assign adj_fire     = adj_edge & {4{~CE}};

    assign run  = CE & ~OVERFLOW;
    assign tick = impulse_edge & run;
    assign sw   = switch_edge & run;

    // A switch coinciding with a tick is deferred one cycle and dropped if that tick flagged.
    assign pending_d = sw & tick;
    assign do_switch = (sw & ~tick) | (pending_q & ~OVERFLOW);

    for (genvar i = 0; i < PLAYERS; i++) begin : gen_player
        logic sel_active, sel_adj;
        assign sel_active = (active_q == AW'(i));
        assign sel_adj    = (ADJ_SEL == AW'(i));

        bcd_time_counter #(
            .INIT_MIN (INIT_MIN),
            .INIT_SEC (INIT_SEC)
`ifdef CHESS_TIMER_INCREMENT_EN
            ,
            .INC_SEC  (INC_SEC)
`endif
        ) u_counter (
            .clk       (CLK),
            .clr       (CLR),
            .tick      (tick & sel_active),
            .inc       (do_switch & sel_active),
            .adj_dec   (sel_adj ? adj_fire : 4'b0000),
            .value     (times[i]),
            .next_zero (next_zero[i])
        );
    end

    always_comb begin
        flag_d = flag_q;
        for (int i = 0; i < PLAYERS; i++) begin
            if (tick && active_q == AW'(i) && next_zero[i]) begin
                flag_d[i] = 1'b1;
            end
            if (adj_fire != 4'b0000 && ADJ_SEL == AW'(i) && !next_zero[i]) begin
                flag_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        active_d = active_q;
        if (do_switch) begin
            active_d = (active_q == AW'(PLAYERS - 1)) ? '0 : active_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            impulse_q <= 1'b1;
            switch_q  <= 1'b1;
            adj_q     <= 4'b1111;
            pending_q <= 1'b0;
            active_q  <= '0;
            flag_q    <= '0;
        end else begin
            impulse_q <= IMPULSE;
            switch_q  <= SWITCH;
            adj_q     <= ADJ_DEC;
            pending_q <= pending_d;
            active_q  <= active_d;
            flag_q    <= flag_d;
        end
    end

    always_comb begin
        disp_time = '0;
        for (int i = 0; i < PLAYERS; i++) begin
            if (DISP_SEL == AW'(i)) disp_time = times[i];
        end
    end

    assign sec_units = disp_time.us;
    assign sec_tens  = disp_time.ts;
    assign min_units = disp_time.um;
    assign min_tens  = disp_time.tm;
    assign ACTIVE    = active_q;
    assign FLAG      = flag_q;
    assign OVERFLOW  = |flag_q;

endmodule
